// File: rtl/pe_mac_ocp_pkg.sv
// Shared types and sizing helpers for the multi-output-channel MAC processing element.
package pe_mac_ocp_pkg;

  typedef enum logic [1:0] {
    INVALID = 2'd0,
    VALID   = 2'd1,
    CNN_FIN = 2'd2
  } pe_state_t;

  localparam int SHIFT_B = 5;

  function automatic int acc_w(input int data_wid, input int icp_num, input int cap_b);
    return 2 * data_wid + $clog2(icp_num) + cap_b;
  endfunction

  // The unused encoding 3 folds onto INVALID so it behaves as a bubble.
  function automatic pe_state_t decode_state(input logic [1:0] raw);
    if (raw == 2'd1) return VALID;
    if (raw == 2'd2) return CNN_FIN;
    return INVALID;
  endfunction

endpackage

// File: rtl/pe_wbuf.sv
// Single-lane weight memory: synchronous write, synchronous read, read-before-write on collision.
module pe_wbuf #(
  parameter int DATA_WID = 8,
  parameter int ADDR_B   = 4
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_B-1:0]   waddr,
  input  logic [DATA_WID-1:0] wdata,
  input  logic [ADDR_B-1:0]   raddr,
  output logic [DATA_WID-1:0] rdata
);

  logic [DATA_WID-1:0] mem [2**ADDR_B];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/pe_mac_ocp.sv
// Multi-output-channel MAC PE: per-lane weight buffers, product tree, windowed accumulate and requantise.
module pe_mac_ocp
  import pe_mac_ocp_pkg::*;
#(
  parameter int DATA_WID = 8,
  parameter int ICP_NUM  = 4,
  parameter int OCP_NUM  = 2,
  parameter int ADDR_B   = 4,
  parameter int CAP_B    = 9
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [1:0]                        in_state,
  input  logic [ICP_NUM-1:0][DATA_WID-1:0]  a,
  input  logic [DATA_WID-1:0]               wrb_data,
  input  logic [ADDR_B-1:0]                 wrb_addr,
  input  logic [ICP_NUM*OCP_NUM-1:0]        wrb,
  input  logic [ADDR_B-1:0]                 rdb_addr,
  input  logic [SHIFT_B-1:0]                out_shift,
  input  logic                              relu_en,
  output logic [1:0]                        out_state,
  output logic [OCP_NUM-1:0][DATA_WID-1:0]  data
);

  localparam int ACC_W  = acc_w(DATA_WID, ICP_NUM, CAP_B);
  localparam int PROD_W = 2 * DATA_WID;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_WID - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  function automatic logic signed [PROD_W-1:0] widen(input logic [DATA_WID-1:0] v);
    return {{DATA_WID{v[DATA_WID-1]}}, v};
  endfunction

  function automatic logic signed [ACC_W-1:0] acc_ext(input logic signed [PROD_W-1:0] p);
    return {{(ACC_W - PROD_W){p[PROD_W-1]}}, p};
  endfunction

  // Shift first, then ReLU, then clamp into the signed result range.
  function automatic logic [DATA_WID-1:0] requant(input logic signed [ACC_W-1:0] v,
                                                  input logic [SHIFT_B-1:0]    sh,
                                                  input logic                  relu);
    logic signed [ACC_W-1:0] s;
    s = v >>> sh;
    if (relu && s[ACC_W-1]) s = '0;
    if (s > SAT_MAX) return SAT_MAX[DATA_WID-1:0];
    if (s < SAT_MIN) return SAT_MIN[DATA_WID-1:0];
    return s[DATA_WID-1:0];
  endfunction

  pe_state_t st_p0, st_p1, st_p2;

  logic [ICP_NUM-1:0][DATA_WID-1:0] a_p0;
  logic [DATA_WID-1:0]              w_p0    [OCP_NUM][ICP_NUM];
  logic signed [PROD_W-1:0]         prod_p1 [OCP_NUM][ICP_NUM];
  logic signed [ACC_W-1:0]          sum_c   [OCP_NUM];
  logic signed [ACC_W-1:0]          sum_p2  [OCP_NUM];
  logic signed [ACC_W-1:0]          acc     [OCP_NUM];
  logic signed [ACC_W-1:0]          total_c [OCP_NUM];

  // ---- E0: weight read issued alongside activation capture
  for (genvar oc = 0; oc < OCP_NUM; oc++) begin : g_oc
    for (genvar ic = 0; ic < ICP_NUM; ic++) begin : g_ic
      pe_wbuf #(
        .DATA_WID (DATA_WID),
        .ADDR_B   (ADDR_B)
      ) u_wbuf (
        .clk   (clk),
        .we    (wrb[oc*ICP_NUM + ic]),
        .waddr (wrb_addr),
        .wdata (wrb_data),
        .raddr (rdb_addr),
        .rdata (w_p0[oc][ic])
      );
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_p0 <= INVALID;
      st_p1 <= INVALID;
      st_p2 <= INVALID;
    end else begin
      st_p0 <= decode_state(in_state);
      st_p1 <= st_p0;
      st_p2 <= st_p1;
    end
  end

  // ---- E1: lane products; E2: per-channel adder tree
  always_comb begin
    for (int oc = 0; oc < OCP_NUM; oc++) begin
      sum_c[oc] = '0;
      for (int ic = 0; ic < ICP_NUM; ic++) begin
        sum_c[oc] = sum_c[oc] + acc_ext(prod_p1[oc][ic]);
      end
    end
  end

  always_ff @(posedge clk) begin
    a_p0 <= a;
    for (int oc = 0; oc < OCP_NUM; oc++) begin
      for (int ic = 0; ic < ICP_NUM; ic++) begin
        prod_p1[oc][ic] <= widen(a_p0[ic]) * widen(w_p0[oc][ic]);
      end
      sum_p2[oc] <= sum_c[oc];
    end
  end

  // ---- E3: accumulate; CNN_FIN folds its own beat in, emits, and restarts from zero
  always_comb begin
    for (int oc = 0; oc < OCP_NUM; oc++) begin
      total_c[oc] = acc[oc] + sum_p2[oc];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_state <= INVALID;
      for (int oc = 0; oc < OCP_NUM; oc++) begin
        acc[oc]  <= '0;
        data[oc] <= '0;
      end
    end else begin
      out_state <= INVALID;
      if (st_p2 == VALID) begin
        for (int oc = 0; oc < OCP_NUM; oc++) acc[oc] <= total_c[oc];
      end else if (st_p2 == CNN_FIN) begin
        out_state <= VALID;
        for (int oc = 0; oc < OCP_NUM; oc++) begin
          acc[oc]  <= '0;
          data[oc] <= requant(total_c[oc], out_shift, relu_en);
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_mac_ocp.sv
// Directed bench for pe_mac_ocp with a window-level reference model and per-cycle output compare.
module tb_pe_mac_ocp;

  logic             clk;
  logic             reset;
  logic [1:0]       in_state;
  logic [3:0][7:0]  a;
  logic [7:0]       wrb_data;
  logic [3:0]       wrb_addr;
  logic [7:0]       wrb;
  logic [3:0]       rdb_addr;
  logic [4:0]       out_shift;
  logic             relu_en;
  logic [1:0]       out_state;
  logic [1:0][7:0]  data;

  pe_mac_ocp #(
    .DATA_WID (8),
    .ICP_NUM  (4),
    .OCP_NUM  (2),
    .ADDR_B   (4),
    .CAP_B    (9)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_state  (in_state),
    .a         (a),
    .wrb_data  (wrb_data),
    .wrb_addr  (wrb_addr),
    .wrb       (wrb),
    .rdb_addr  (rdb_addr),
    .out_shift (out_shift),
    .relu_en   (relu_en),
    .out_state (out_state),
    .data      (data)
  );

  typedef struct {
    int cyc;
    int d0;
    int d1;
  } exp_t;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  exp_t   q[$];
  int     wmem [2][4][16];
  longint m_acc [2];
  int     m_fin0, m_fin1;
  int     last0 = 0, last1 = 0;
  int     cap0 = 0, cap1 = 0, cap_cyc = 0, cap_gap = 0, vld_cnt = 0;
  int     fin_edge = 0, win_start = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: no summary after %0d cycles", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int post(input longint v);
    longint s;
    s = v >>> out_shift;
    if (relu_en && s < 0) s = 0;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return int'(s);
  endfunction

  // Every cycle outside reset: VALID only on a scheduled result, data holds the last result.
  always @(negedge clk) begin
    if (reset) begin
      check("reset_out_state", out_state, 0);
      check("reset_data0", $signed(data[0]), 0);
      check("reset_data1", $signed(data[1]), 0);
    end else begin
      int exp_vld;
      exp_vld = 0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        exp_vld = 1;
        last0 = q[0].d0;
        last1 = q[0].d1;
        void'(q.pop_front());
      end
      check("out_state", out_state, exp_vld);
      check("data0", $signed(data[0]), last0);
      check("data1", $signed(data[1]), last1);
      if (out_state == 2'd1) begin
        cap0    = $signed(data[0]);
        cap1    = $signed(data[1]);
        cap_gap = cyc - cap_cyc;
        cap_cyc = cyc;
        vld_cnt++;
      end
    end
  end

  task automatic beat(input int st, input int a0, input int a1, input int a2, input int a3,
                      input int ra, input logic [7:0] wm, input int wa, input int wd);
    int av[4];
    av = '{a0, a1, a2, a3};
    in_state = 2'(st);
    for (int ic = 0; ic < 4; ic++) a[ic] = 8'(av[ic]);
    rdb_addr = 4'(ra);
    wrb      = wm;
    wrb_addr = 4'(wa);
    wrb_data = 8'(wd);
    if (st == 1 || st == 2) begin
      for (int oc = 0; oc < 2; oc++)
        for (int ic = 0; ic < 4; ic++)
          m_acc[oc] += longint'(av[ic]) * longint'(wmem[oc][ic][ra]);
    end
    if (st == 2) begin
      m_fin0 = post(m_acc[0]);
      m_fin1 = post(m_acc[1]);
      q.push_back('{cyc + 4, m_fin0, m_fin1});
      fin_edge = cyc + 1;
      m_acc[0] = 0;
      m_acc[1] = 0;
    end
    for (int b = 0; b < 8; b++) if (wm[b]) wmem[b / 4][b % 4][wa] = wd;
    @(negedge clk);
  endtask

  task automatic mac(input int st, input int a0, input int a1, input int a2, input int a3,
                     input int ra);
    beat(st, a0, a1, a2, a3, ra, 8'h00, 0, 0);
  endtask

  task automatic wr(input logic [7:0] wm, input int wa, input int wd);
    beat(0, 0, 0, 0, 0, 0, wm, wa, wd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) mac(0, 0, 0, 0, 0, 0);
  endtask

  // Nine-beat window a[ic]=16*ic+k at address k, with optional bubbles after beat 3.
  task automatic win9(input int bubbles);
    win_start = cyc + 1;
    for (int k = 0; k < 9; k++) begin
      if (k == 4) idle(bubbles);
      mac((k == 8) ? 2 : 1, k, 16 + k, 32 + k, 48 + k, k);
    end
  endtask

  task automatic pin(input string name, input int e0, input int e1);
    check({name, "_dut_d0"}, cap0, e0);
    check({name, "_dut_d1"}, cap1, e1);
    check({name, "_model_d0"}, m_fin0, e0);
    check({name, "_model_d1"}, m_fin1, e1);
  endtask

  task automatic do_reset();
    in_state = 2'd0;
    wrb      = 8'h00;
    #2 reset = 1'b1;
    m_acc[0] = 0;
    m_acc[1] = 0;
    q.delete();
    last0 = 0;
    last1 = 0;
    @(negedge clk);
    check("midreset_out_state", out_state, 0);
    check("midreset_data0", $signed(data[0]), 0);
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n0;
    in_state  = 2'd0;
    a         = '0;
    wrb_data  = '0;
    wrb_addr  = '0;
    wrb       = '0;
    rdb_addr  = '0;
    out_shift = 5'd3;
    relu_en   = 1'b0;
    reset     = 1'b0;
    m_acc[0]  = 0;
    m_acc[1]  = 0;
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("init_out_state", out_state, 0);
    check("init_data0", $signed(data[0]), 0);
    #2 reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 9; k++) begin
      wr(8'h0F, k, 1);
      wr(8'hF0, k, -1);
    end
    wr(8'hFF, 9, 1);
    wr(8'hFF, 10, 1);

    win9(0);
    idle(6);
    pin("shift3", 126, -126);
    check("shift3_latency", cap_cyc - fin_edge, 3);
    check("shift3_span", cap_cyc - win_start, 11);

    out_shift = 5'd0;
    win9(0);
    idle(6);
    pin("saturate", 127, -128);

    relu_en = 1'b1;
    win9(0);
    idle(6);
    pin("relu", 127, 0);
    relu_en = 1'b0;

    out_shift = 5'd3;
    win9(3);
    idle(6);
    pin("bubbles", 126, -126);
    check("bubbles_span", cap_cyc - win_start, 14);

    out_shift = 5'd0;
    n0 = vld_cnt;
    mac(1, 1, 1, 1, 1, 9);
    mac(2, 1, 1, 1, 1, 10);
    mac(1, 1, 1, 1, 1, 9);
    mac(2, 1, 1, 1, 1, 10);
    idle(6);
    pin("back2back", 8, 8);
    check("back2back_gap", cap_gap, 2);
    check("back2back_count", vld_cnt - n0, 2);

    wr(8'h01, 5, 2);
    beat(2, 1, 0, 0, 0, 5, 8'h01, 5, 7);
    idle(6);
    pin("rw_collide", 2, -1);
    mac(2, 1, 0, 0, 0, 5);
    idle(6);
    pin("rw_after", 7, -1);

    for (int i = 0; i < 4; i++) mac(1, 1, 1, 1, 1, 9);
    do_reset();
    mac(2, 1, 1, 1, 1, 9);
    idle(6);
    pin("post_reset", 4, 4);

    check("valid_count", vld_cnt, 9);
    check("queue_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
